// File: rtl/complex_result_serializer.sv
// ============================================================================
// Module   : complex_result_serializer
// Brief    : Buffers double-width complex row-result words in a small FIFO and
//            serialises each into (real, imag) elements over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_result_serializer #(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4,
    parameter int ELEMENT_WIDTH               = 64,
    parameter int FIFO_DEPTH                  = 4
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic [2*ELEMENT_WIDTH*NO_OF_ROW_BY_VECTOR_MODULES-1:0]        in_word,
    input  logic                                                          in_strobe,
    output logic [ELEMENT_WIDTH-1:0]                                      out_real,
    output logic [ELEMENT_WIDTH-1:0]                                      out_imag,
    output logic [$clog2(NO_OF_ROW_BY_VECTOR_MODULES)-1:0]                out_index,
    output logic                                                          out_last,
    output logic                                                          out_valid,
    input  logic                                                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]                                   fifo_count,
    output logic                                                          overflow,
    output logic                                                          busy
);

    localparam int c_N  = NO_OF_ROW_BY_VECTOR_MODULES;
    localparam int c_W  = ELEMENT_WIDTH;
    localparam int c_WW = 2 * c_W * c_N;
    localparam int c_IW = $clog2(c_N);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [c_IW-1:0] c_KLAST = c_IW'(c_N - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(FIFO_DEPTH);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SERVE = 1'b1;

    logic [c_WW-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic [0:0]      r_state;
    logic [c_IW-1:0] r_k;
    logic [c_WW-1:0] r_word;

    logic w_empty;
    logic w_hs;
    logic w_pop;
    logic w_push;
    logic w_drop;

    logic [c_W-1:0] w_re [c_N];
    logic [c_W-1:0] w_im [c_N];

    assign w_empty = (r_count == '0);
    assign w_hs    = (r_state == c_S_SERVE) && out_ready;
    // Pop either to start a fresh word from IDLE, or to chain the next word
    // directly onto the last-element handshake so no bubble appears.
    assign w_pop   = !w_empty && ((r_state == c_S_IDLE) || (w_hs && (r_k == c_KLAST)));
    assign w_push  = in_strobe && ((r_count != c_FULL) || w_pop);
    assign w_drop  = in_strobe && (r_count == c_FULL) && !w_pop;

    for (genvar g = 0; g < c_N; g++) begin : g_elem
        assign w_re[g] = r_word[c_W*c_N + c_W*g +: c_W];
        assign w_im[g] = r_word[c_W*g +: c_W];
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_state    <= c_S_IDLE;
            r_k        <= '0;
            r_word     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_word  <= r_mem[r_rd_ptr];
                        r_k     <= '0;
                        r_state <= c_S_SERVE;
                    end
                end
                c_S_SERVE: begin
                    if (w_hs) begin
                        if (r_k != c_KLAST) begin
                            r_k <= r_k + c_IW'(1);
                        end else if (w_pop) begin
                            r_word <= r_mem[r_rd_ptr];
                            r_k    <= '0;
                        end else begin
                            r_k     <= '0;
                            r_state <= c_S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = (r_state == c_S_SERVE);
    assign out_real   = w_re[r_k];
    assign out_imag   = w_im[r_k];
    assign out_index  = r_k;
    assign out_last   = out_valid && (r_k == c_KLAST);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = out_valid || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_complex_result_serializer.sv
// ============================================================================
// Module   : tb_complex_result_serializer
// Brief    : Directed self-checking bench for complex_result_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complex_result_serializer;

    localparam int W = 64;
    localparam int N = 4;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2*W*N-1:0]     in_word;
    logic                 in_strobe;
    logic [W-1:0]         out_real;
    logic [W-1:0]         out_imag;
    logic [1:0]           out_index;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           fifo_count;
    logic                 overflow;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_re [$];
    logic [W-1:0] exp_im [$];
    int           exp_ix [$];

    complex_result_serializer #(
        .NO_OF_ROW_BY_VECTOR_MODULES(N),
        .ELEMENT_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_strobe(in_strobe),
        .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W*N-1:0] make_word(input logic [W-1:0] rb, input logic [W-1:0] ib);
        logic [2*W*N-1:0] w;
        w = '0;
        for (int k = 0; k < N; k++) begin
            w[W*N + W*k +: W] = rb + W'(k);
            w[W*k +: W]       = ib + W'(k);
        end
        return w;
    endfunction

    task automatic push_exp(input logic [W-1:0] rb, input logic [W-1:0] ib);
        for (int k = 0; k < N; k++) begin
            exp_re.push_back(rb + W'(k));
            exp_im.push_back(ib + W'(k));
            exp_ix.push_back(k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_strobe = 1'b0; out_ready = 1'b0; in_word = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_re.delete(); exp_im.delete(); exp_ix.delete();
    endtask

    // Drive one strobe on the current negedge, return at the next negedge.
    task automatic strobe(input logic [W-1:0] rb, input logic [W-1:0] ib);
        in_word = make_word(rb, ib); in_strobe = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
    endtask

    // pattern 0: always ready; pattern 1: ready 1,0,0 repeating.
    task automatic drain(input int n, input int pattern, input bit contiguous);
        int got = 0; int cyc = 0; int ph = 0; bit started = 0; bit holding = 0;
        logic [W-1:0] hr, hi; logic [1:0] hx;
        logic [W-1:0] er, ei; int ex;
        while (got < n && cyc < 400) begin
            out_ready = (pattern == 0) ? 1'b1 : ((ph % 3) == 0);
            ph++;
            if (holding) begin
                total++;
                if (out_valid !== 1'b1 || out_real !== hr || out_imag !== hi || out_index !== hx) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%0b re=%0h im=%0h k=%0d want re=%0h im=%0h k=%0d",
                             out_valid, out_real, out_imag, out_index, hr, hi, hx);
                end
            end
            if (contiguous && started) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL no_bubble: got out_valid=%0b want 1 at element %0d", out_valid, got);
                end
            end
            holding = 1'b0;
            if (out_valid === 1'b1) begin
                started = 1'b1;
                if (out_ready) begin
                    er = exp_re.pop_front(); ei = exp_im.pop_front(); ex = exp_ix.pop_front();
                    total++;
                    if (out_real !== er || out_imag !== ei || out_index !== 2'(ex) || out_last !== (ex == N-1)) begin
                        bad++;
                        $display("FAIL element %0d: got re=%0h im=%0h k=%0d last=%0b want re=%0h im=%0h k=%0d last=%0b",
                                 got, out_real, out_imag, out_index, out_last, er, ei, ex, (ex == N-1));
                    end
                    got++;
                end else begin
                    holding = 1'b1; hr = out_real; hi = out_imag; hx = out_index;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d elements want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_strobe = 1'b1; out_ready = 1'b1;
        in_word = make_word(64'hAA, 64'hBB);
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        total++; if (out_index !== 2'd0)  begin bad++; $display("FAIL rst_index: got %0d want 0", out_index); end
        total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL rst_last: got %0b want 0", out_last); end
        total++; if (out_real !== '0 || out_imag !== '0) begin
            bad++; $display("FAIL rst_data: got re=%0h im=%0h want 0 0", out_real, out_imag); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        rst = 1'b0; in_strobe = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL rst_no_write: got valid=%0b count=%0d want 0 0", out_valid, fifo_count); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        push_exp(64'h100, 64'h200);
        strobe(64'h100, 64'h200);
        total++; if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin
            bad++; $display("FAIL lat_edge1: got valid=%0b count=%0d want 0 1", out_valid, fifo_count); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL lat_edge2: got valid=%0b count=%0d busy=%0b want 1 0 1", out_valid, fifo_count, busy); end
        drain(4, 0, 1'b1);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_idle: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_exp(64'h100, 64'h200);
        strobe(64'h100, 64'h200);
        @(negedge clk);
        drain(4, 1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_extra: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_exp(64'hA00, 64'hA80);
        push_exp(64'hB00, 64'hB80);
        push_exp(64'hC00, 64'hC80);
        in_strobe = 1'b1;
        in_word = make_word(64'hA00, 64'hA80); @(negedge clk);
        in_word = make_word(64'hB00, 64'hB80); @(negedge clk);
        in_word = make_word(64'hC00, 64'hC80); @(negedge clk);
        in_strobe = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
        drain(12, 0, 1'b1);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_exp(64'h1000 + 64'(i*16), 64'h2000 + 64'(i*16));
            strobe(64'h1000 + 64'(i*16), 64'h2000 + 64'(i*16));
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        drain(20, 0, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_after: got ovf=%0b busy=%0b valid=%0b want 1 0 0", overflow, busy, out_valid); end
    endtask

    task automatic test_full_with_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_exp(64'h3000 + 64'(i*16), 64'h4000 + 64'(i*16));
            strobe(64'h3000 + 64'(i*16), 64'h4000 + 64'(i*16));
        end
        push_exp(64'h3050, 64'h4050);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        drain(3, 0, 1'b0);
        total++; if (out_index !== 2'd3 || out_last !== 1'b1) begin
            bad++; $display("FAIL full_at_last: got k=%0d last=%0b want 3 1", out_index, out_last); end
        out_ready = 1'b1;
        in_word = make_word(64'h3050, 64'h4050); in_strobe = 1'b1;
        void'(exp_re.pop_front()); void'(exp_im.pop_front()); void'(exp_ix.pop_front());
        @(negedge clk);
        in_strobe = 1'b0; out_ready = 1'b0;
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_pop_push: got count=%0d ovf=%0b want 4 0", fifo_count, overflow); end
        total++; if (out_valid !== 1'b1 || out_index !== 2'd0 || out_real !== 64'h3010) begin
            bad++; $display("FAIL full_next_word: got v=%0b k=%0d re=%0h want 1 0 3010", out_valid, out_index, out_real); end
        drain(20, 0, 1'b1);
        out_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_end: got %0b want 0", overflow); end
    endtask

    task automatic test_reset_mid_serve();
        int seen;
        do_reset();
        push_exp(64'h5000, 64'h6000);
        for (int i = 0; i < 3; i++) strobe(64'h5000 + 64'(i*16), 64'h6000 + 64'(i*16));
        drain(2, 0, 1'b0);
        total++; if (out_index !== 2'd2 || fifo_count !== 3'd2) begin
            bad++; $display("FAIL mid_pre: got k=%0d count=%0d want 2 2", out_index, fifo_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_post: got v=%0b count=%0d busy=%0b want 0 0 0", out_valid, fifo_count, busy); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_silent: got %0d valid cycles want 0", seen); end
        exp_re.delete(); exp_im.delete(); exp_ix.delete();
        out_ready = 1'b0;
        push_exp(64'h7000, 64'h7800);
        strobe(64'h7000, 64'h7800);
        drain(4, 0, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_strobe = 1'b0; out_ready = 1'b0; in_word = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_with_pop();
        test_reset_mid_serve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/complex_result_serializer.md
Name: complex_result_serializer

Overview:
- Sits directly downstream of the complex decoder-with-control stage.
- Captures each assembled double-width complex row-result word on the decoder's one-cycle read strobe and buffers it in a small word FIFO.
- Serialises each word into one complex element (real, imag) per valid/ready handshake for the downstream writeback/accumulation logic.
- The upstream stage cannot be stalled, so overflow is detected and flagged, never back-pressured.

Parameters:
- no_of_row_by_vector_modules, 4, complex elements per assembled word (N).
- element_width, 64, bits per real or imaginary part (W).
- fifo_depth, 4, buffered words; power of two, at least 2.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_word, input, 2*W*N, assembled word; upper half [2WN-1:WN] = real parts (first beat), lower half [WN-1:0] = imaginary parts (second beat).
- in_strobe, input, 1, one-cycle write strobe (decoder's outsider_read_now).
- out_real, output, W, real part of current element.
- out_imag, output, W, imaginary part of current element.
- out_index, output, clog2(N), element index k within the word.
- out_last, output, 1, high when k = N-1.
- out_valid, output, 1, element presented.
- out_ready, input, 1, downstream accepts.
- fifo_count, output, clog2(fifo_depth)+1, words held in FIFO, excluding the word being served.
- overflow, output, 1, sticky; a strobe was dropped.
- busy, output, 1, serializer holds a word or FIFO is non-empty.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - out_valid=0, out_index=0, out_last=0, out_real=0, out_imag=0.
  - fifo_count=0, overflow=0, busy=0.
  - FIFO read/write pointers cleared; serializer state IDLE.
  - Reset mid-operation discards all buffered and in-flight words; no element handshakes after reset until a new strobe.
- Element mapping for element k:
  - real = in_word[W*N + W*(k+1)-1 : W*N + W*k]
  - imag = in_word[W*(k+1)-1 : W*k]
  - No arithmetic; bits pass through unchanged.
- FIFO write:
  - in_strobe=1 and (fifo_count<fifo_depth or a pop occurs the same cycle) -> word written at write pointer.
  - Pointers wrap modulo fifo_depth.
- Overflow:
  - in_strobe=1, fifo_count=fifo_depth, no pop that cycle -> word dropped, overflow set and held until rst.
- State machine, two states:
  - IDLE: out_valid=0. If FIFO non-empty, pop the head into the serve register, set k=0, go to SERVE.
  - SERVE: out_valid=1. On out_valid&&out_ready:
    - If k<N-1: k<=k+1.
    - If k=N-1 and FIFO non-empty: pop the next word, k=0, stay in SERVE (back-to-back, no bubble).
    - If k=N-1 and FIFO empty: go to IDLE.
  - Without out_ready, all outputs hold stable.
- Bypass: a strobe into an empty FIFO in IDLE does not bypass. The word is written at edge t, popped at edge t+1, and out_valid=1 from cycle t+1 (latency 2 edges from strobe to first element presented).
- Simultaneous write and pop: fifo_count unchanged; both occur.
- Strobe on consecutive cycles is legal; each strobe is one word.
- fifo_count updates the cycle after write/pop.
- out_last = (out_index==N-1) && out_valid.

Test Plan:
- Reset defaults: hold rst 2 cycles with in_strobe=1 -> all outputs 0, fifo_count=0, no write.
- Single word, W=64, N=4: real_k=0x100+k, imag_k=0x200+k, one strobe, out_ready=1 -> out_valid rises 2 edges later. Four handshakes k=0..3 show (0x100,0x200)…(0x103,0x203). out_last only on k=3. Then IDLE, busy=0.
- Back-pressure: same word, out_ready toggling 1,0,0,1… -> outputs stable while out_ready=0. Exactly 4 handshakes, same values in order.
- Back-to-back: 3 strobes on consecutive cycles with words A, B, C; out_ready=1 -> 12 contiguous handshakes, A0..A3 B0..B3 C0..C3, out_valid never drops between words.
- Overflow: out_ready=0, 6 strobes -> first word in serve register, FIFO fills at 4, 6th strobe dropped, overflow=1. Release out_ready -> 5 words (20 elements) emerge; overflow stays 1.
- Full with simultaneous pop: FIFO=4, strobe coincides with a last-element handshake -> word accepted, overflow stays 0, fifo_count stays 4.
- Reset mid-serve: assert rst at k=2 of a word with 2 words queued -> next cycle out_valid=0, fifo_count=0. No further elements until a new strobe.
